// File: rtl/alu_denetleyici_pkg.sv
// Shared definitions for the ALU command sequencer: opcodes, FSM states and
// command-word field positions.
package alu_denetleyici_pkg;

    localparam logic [2:0] TOPLA       = 3'b000;
    localparam logic [2:0] CIKAR       = 3'b001;
    localparam logic [2:0] ARTIR       = 3'b010;
    localparam logic [2:0] KARE        = 3'b011;
    localparam logic [2:0] KARSILASTIR = 3'b100;
    localparam logic [2:0] YUKLE       = 3'b101;

    typedef enum logic [1:0] {
        BOS   = 2'd0,
        OKU   = 2'd1,
        YURUT = 2'd2,
        YAZ   = 2'd3
    } durum_t;

    localparam int ISLEM_MSB   = 11;
    localparam int ISLEM_LSB   = 9;
    localparam int HEDEF_MSB   = 8;
    localparam int HEDEF_LSB   = 6;
    localparam int KAYNAK1_MSB = 5;
    localparam int KAYNAK1_LSB = 3;
    localparam int KAYNAK2_MSB = 2;
    localparam int KAYNAK2_LSB = 0;

    // Codes the external ALU understands; everything above is load or illegal.
    function automatic logic alu_islemi_mi(input logic [2:0] islem);
        return islem <= KARSILASTIR;
    endfunction

endpackage

// File: rtl/alu_denetleyici_yazmac_dosyasi.sv
// 8x8 register file: two combinational operand reads, one registered debug
// read, one write port, asynchronous clear.
module yazmac_dosyasi (
    input  logic       clk_in,
    input  logic       rstn_in,
    input  logic       yaz_en_in,
    input  logic [2:0] yaz_adr_in,
    input  logic [7:0] yaz_veri_in,
    input  logic [2:0] oku1_adr_in,
    output logic [7:0] oku1_veri_out,
    input  logic [2:0] oku2_adr_in,
    output logic [7:0] oku2_veri_out,
    input  logic [2:0] dbg_adr_in,
    output logic [7:0] dbg_veri_out
);

    logic [7:0] rf_q [8];
    logic [7:0] dbg_q;

    assign oku1_veri_out = rf_q[oku1_adr_in];
    assign oku2_veri_out = rf_q[oku2_adr_in];
    assign dbg_veri_out  = dbg_q;

    // Storage array with write port; cleared on reset.
    always_ff @(posedge clk_in or negedge rstn_in) begin
        if (!rstn_in) begin
            for (int i = 0; i < 8; i++) begin
                rf_q[i] <= '0;
            end
        end else if (yaz_en_in) begin
            rf_q[yaz_adr_in] <= yaz_veri_in;
        end
    end

    // Debug read samples pre-write contents, so a same-cycle write shows old data.
    always_ff @(posedge clk_in or negedge rstn_in) begin
        if (!rstn_in) begin
            dbg_q <= '0;
        end else begin
            dbg_q <= rf_q[dbg_adr_in];
        end
    end

endmodule

// File: rtl/alu_denetleyici.sv
// Command sequencer feeding an external combinational ALU from a local
// register file, with immediate load and a debug read port.
//
// state | meaning
// BOS   | idle, ready for a command
// OKU   | operands read from register file
// YURUT | ALU evaluating registered operands
// YAZ   | result written back, valid pulse
module alu_denetleyici
    import alu_denetleyici_pkg::*;
(
    input  logic        clk_in,
    input  logic        rstn_in,
    input  logic        komut_gecerli_in,
    output logic        komut_hazir_out,
    input  logic [11:0] komut_in,
    input  logic [7:0]  veri_in,
    output logic [2:0]  islem_out,
    output logic [7:0]  s1_out,
    output logic [7:0]  s2_out,
    input  logic [7:0]  sonuc_in,
    output logic [7:0]  sonuc_out,
    output logic        sonuc_gecerli_out,
    output logic        hata_out,
    input  logic [2:0]  okuma_adr_in,
    output logic [7:0]  okuma_veri_out
);

    durum_t      durum_q, durum_d;
    logic [11:0] komut_q;
    logic [7:0]  veri_q;
    logic [2:0]  islem_q;
    logic [7:0]  s1_q, s2_q;
    logic [7:0]  sonuc_q;
    logic        hata_q, hata_d;
    logic        yaz_en;
    logic [7:0]  oku1_veri, oku2_veri;

    logic [2:0] islem_w, hedef_w, kaynak1_w, kaynak2_w;
    assign islem_w   = komut_q[ISLEM_MSB:ISLEM_LSB];
    assign hedef_w   = komut_q[HEDEF_MSB:HEDEF_LSB];
    assign kaynak1_w = komut_q[KAYNAK1_MSB:KAYNAK1_LSB];
    assign kaynak2_w = komut_q[KAYNAK2_MSB:KAYNAK2_LSB];

    yazmac_dosyasi u_rf (
        .clk_in        (clk_in),
        .rstn_in       (rstn_in),
        .yaz_en_in     (yaz_en),
        .yaz_adr_in    (hedef_w),
        .yaz_veri_in   (sonuc_q),
        .oku1_adr_in   (kaynak1_w),
        .oku1_veri_out (oku1_veri),
        .oku2_adr_in   (kaynak2_w),
        .oku2_veri_out (oku2_veri),
        .dbg_adr_in    (okuma_adr_in),
        .dbg_veri_out  (okuma_veri_out)
    );

    // State register.
    always_ff @(posedge clk_in or negedge rstn_in) begin
        if (!rstn_in) begin
            durum_q <= BOS;
        end else begin
            durum_q <= durum_d;
        end
    end

    // Next-state logic.
    always_comb begin
        durum_d = durum_q;
        case (durum_q)
            BOS: begin
                if (komut_gecerli_in) begin
                    durum_d = OKU;
                end
            end
            OKU: begin
                if (alu_islemi_mi(islem_w)) begin
                    durum_d = YURUT;
                end else if (islem_w == YUKLE) begin
                    durum_d = YAZ;
                end else begin
                    durum_d = BOS;
                end
            end
            YURUT:   durum_d = YAZ;
            YAZ:     durum_d = BOS;
            default: durum_d = BOS;
        endcase
    end

    // State-decoded outputs and strobes.
    always_comb begin
        komut_hazir_out   = (durum_q == BOS);
        sonuc_gecerli_out = (durum_q == YAZ);
        yaz_en            = (durum_q == YAZ);
        hata_d            = (durum_q == OKU) && !alu_islemi_mi(islem_w)
                            && (islem_w != YUKLE);
    end

    // Command latch, ALU operand registers and result register.
    always_ff @(posedge clk_in or negedge rstn_in) begin
        if (!rstn_in) begin
            komut_q <= '0;
            veri_q  <= '0;
            islem_q <= TOPLA;
            s1_q    <= '0;
            s2_q    <= '0;
            sonuc_q <= '0;
            hata_q  <= 1'b0;
        end else begin
            hata_q <= hata_d;
            case (durum_q)
                BOS: begin
                    if (komut_gecerli_in) begin
                        komut_q <= komut_in;
                        veri_q  <= veri_in;
                    end
                end
                OKU: begin
                    if (alu_islemi_mi(islem_w)) begin
                        islem_q <= islem_w;
                        s1_q    <= oku1_veri;
                        s2_q    <= oku2_veri;
                    end else if (islem_w == YUKLE) begin
                        sonuc_q <= veri_q;
                    end
                end
                YURUT: begin
                    sonuc_q <= sonuc_in;
                end
                default: ;
            endcase
        end
    end

    assign islem_out = islem_q;
    assign s1_out    = s1_q;
    assign s2_out    = s2_q;
    assign sonuc_out = sonuc_q;
    assign hata_out  = hata_q;

endmodule

// File: tb/tb_alu_denetleyici.sv
module tb_alu_denetleyici;

    logic        clk_in = 1'b0;
    logic        rstn_in = 1'b0;
    logic        komut_gecerli_in = 1'b0;
    logic        komut_hazir_out;
    logic [11:0] komut_in = '0;
    logic [7:0]  veri_in = '0;
    logic [2:0]  islem_out;
    logic [7:0]  s1_out, s2_out;
    logic [7:0]  sonuc_in;
    logic [7:0]  sonuc_out;
    logic        sonuc_gecerli_out;
    logic        hata_out;
    logic [2:0]  okuma_adr_in = '0;
    logic [7:0]  okuma_veri_out;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] rf_m [8];

    typedef struct {
        logic [11:0] komut;
        logic [7:0]  veri;
        logic [7:0]  beklenen;
    } vektor_t;

    vektor_t tablo [17];

    alu_denetleyici dut (
        .clk_in            (clk_in),
        .rstn_in           (rstn_in),
        .komut_gecerli_in  (komut_gecerli_in),
        .komut_hazir_out   (komut_hazir_out),
        .komut_in          (komut_in),
        .veri_in           (veri_in),
        .islem_out         (islem_out),
        .s1_out            (s1_out),
        .s2_out            (s2_out),
        .sonuc_in          (sonuc_in),
        .sonuc_out         (sonuc_out),
        .sonuc_gecerli_out (sonuc_gecerli_out),
        .hata_out          (hata_out),
        .okuma_adr_in      (okuma_adr_in),
        .okuma_veri_out    (okuma_veri_out)
    );

    always #5 clk_in = ~clk_in;

    // External combinational ALU beside the controller.
    always_comb begin
        sonuc_in = '0;
        case (islem_out)
            3'b000:  sonuc_in = s1_out + s2_out;
            3'b001:  sonuc_in = s1_out - s2_out;
            3'b010:  sonuc_in = s2_out + 8'd1;
            3'b011:  sonuc_in = 8'(s1_out * s1_out);
            3'b100:  sonuc_in = (s1_out > s2_out) ? 8'd1 : 8'd0;
            default: sonuc_in = '0;
        endcase
    end

    function automatic logic [11:0] mk(input int op, input int h, input int a, input int b);
        return {3'(op), 3'(h), 3'(a), 3'(b)};
    endfunction

    // Reference: what the destination register should hold after a command.
    function automatic int model(input logic [11:0] k, input logic [7:0] v);
        int op, a, b;
        op = int'(k[11:9]);
        a  = int'(rf_m[k[5:3]]);
        b  = int'(rf_m[k[2:0]]);
        case (op)
            0: return (a + b) % 256;
            1: return (a - b + 256) % 256;
            2: return (b + 1) % 256;
            3: return (a * a) % 256;
            4: return (a > b) ? 1 : 0;
            5: return int'(v);
            default: return 0;
        endcase
    endfunction

    task automatic chk(input string ad, input int gercek, input int beklenen);
        n_vec++;
        if (gercek != beklenen) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", ad, gercek, beklenen);
        end
    endtask

    task automatic run_cmd(input logic [11:0] k, input logic [7:0] v,
                           output int lat, output logic [7:0] val, output bit err,
                           output int rdy_mid, output bit rdy_pulse);
        int w;
        lat = 99; val = '0; err = 1'b0; rdy_mid = 0; rdy_pulse = 1'b0;
        w = 0;
        while (!komut_hazir_out && w < 10) begin
            @(negedge clk_in);
            w++;
        end
        komut_gecerli_in = 1'b1;
        komut_in = k;
        veri_in = v;
        @(negedge clk_in);
        komut_gecerli_in = 1'b0;
        komut_in = 12'($urandom);
        veri_in = 8'($urandom);
        for (int c = 1; c <= 8; c++) begin
            if (sonuc_gecerli_out || hata_out) begin
                lat = c;
                val = sonuc_out;
                err = hata_out;
                rdy_pulse = komut_hazir_out;
                break;
            end
            if (komut_hazir_out) rdy_mid++;
            @(negedge clk_in);
        end
    endtask

    task automatic do_cmd(input string tag, input logic [11:0] k, input logic [7:0] v,
                          input bit sabit, input logic [7:0] sabit_deger);
        int lat, rdy_mid, op, bek;
        logic [7:0] val;
        bit err, rdy_pulse;
        op  = int'(k[11:9]);
        bek = sabit ? int'(sabit_deger) : model(k, v);
        run_cmd(k, v, lat, val, err, rdy_mid, rdy_pulse);
        chk({tag, " latency"}, lat, (op <= 4) ? 3 : 2);
        chk({tag, " hata"}, int'(err), (op >= 6) ? 1 : 0);
        if (op < 6) chk({tag, " sonuc"}, int'(val), bek);
        chk({tag, " ready"}, rdy_mid * 2 + int'(rdy_pulse), (op >= 6) ? 1 : 0);
        @(negedge clk_in);
        chk({tag, " post"}, int'({komut_hazir_out, sonuc_gecerli_out, hata_out}), 4);
        if (op < 6) rf_m[k[8:6]] = 8'(bek);
    endtask

    task automatic dbg_read(input logic [2:0] adr, output logic [7:0] val);
        okuma_adr_in = adr;
        @(negedge clk_in);
        val = okuma_veri_out;
    endtask

    task automatic check_all_regs(input string tag);
        logic [7:0] val;
        for (int i = 0; i < 8; i++) begin
            dbg_read(3'(i), val);
            chk($sformatf("%s r%0d", tag, i), int'(val), int'(rf_m[i]));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] val;
        logic [11:0] k;

        tablo[0]  = '{mk(5,1,0,0), 8'h07, 8'h07};
        tablo[1]  = '{mk(5,2,0,0), 8'h05, 8'h05};
        tablo[2]  = '{mk(0,3,1,2), 8'h00, 8'h0C};
        tablo[3]  = '{mk(1,6,2,1), 8'h00, 8'hFE};
        tablo[4]  = '{mk(4,7,1,2), 8'h00, 8'h01};
        tablo[5]  = '{mk(4,7,1,1), 8'h00, 8'h00};
        tablo[6]  = '{mk(5,1,0,0), 8'hFF, 8'hFF};
        tablo[7]  = '{mk(5,2,0,0), 8'hFF, 8'hFF};
        tablo[8]  = '{mk(2,4,0,2), 8'h00, 8'h00};
        tablo[9]  = '{mk(5,1,0,0), 8'h10, 8'h10};
        tablo[10] = '{mk(3,5,1,0), 8'h00, 8'h00};
        tablo[11] = '{mk(5,0,0,0), 8'h03, 8'h03};
        tablo[12] = '{mk(0,0,0,0), 8'h00, 8'h06};
        tablo[13] = '{mk(0,0,0,1), 8'h00, 8'h16};
        tablo[14] = '{mk(1,2,2,0), 8'h00, 8'hE9};
        tablo[15] = '{mk(6,3,1,2), 8'h00, 8'h00};
        tablo[16] = '{mk(7,4,1,2), 8'h00, 8'h00};

        for (int i = 0; i < 8; i++) rf_m[i] = '0;

        // Reset state.
        #12;
        chk("reset outputs", int'({islem_out, s1_out, s2_out, sonuc_out,
                                   sonuc_gecerli_out, hata_out, okuma_veri_out}), 0);
        @(negedge clk_in);
        rstn_in = 1'b1;
        @(negedge clk_in);
        chk("reset ready", int'(komut_hazir_out), 1);

        for (int i = 0; i < 2; i++)
            do_cmd($sformatf("tab%0d", i), tablo[i].komut, tablo[i].veri, 1'b1, tablo[i].beklenen);
        dbg_read(3'd1, val);
        chk("dbg r1", int'(val), 8'h07);
        dbg_read(3'd2, val);
        chk("dbg r2", int'(val), 8'h05);

        for (int i = 2; i < 17; i++)
            do_cmd($sformatf("tab%0d", i), tablo[i].komut, tablo[i].veri, 1'b1, tablo[i].beklenen);
        check_all_regs("after table");

        // Reset during YURUT of r3 = r1 + r2.
        k = mk(0,3,1,2);
        komut_gecerli_in = 1'b1;
        komut_in = k;
        @(negedge clk_in);
        komut_gecerli_in = 1'b0;
        @(negedge clk_in);
        chk("yurut s1", int'(s1_out), int'(rf_m[1]));
        chk("yurut s2", int'(s2_out), int'(rf_m[2]));
        rstn_in = 1'b0;
        #1;
        chk("midreset outputs", int'({islem_out, s1_out, s2_out, sonuc_out,
                                      sonuc_gecerli_out, hata_out, okuma_veri_out}), 0);
        for (int i = 0; i < 8; i++) rf_m[i] = '0;
        @(negedge clk_in);
        rstn_in = 1'b1;
        @(negedge clk_in);
        @(negedge clk_in);
        chk("midreset no pulse", int'({sonuc_gecerli_out, hata_out}), 0);
        check_all_regs("after midreset");
        do_cmd("post-reset load", mk(5,3,0,0), 8'h33, 1'b1, 8'h33);
        dbg_read(3'd3, val);
        chk("post-reset r3", int'(val), 8'h33);

        // Randomized commands against the model.
        for (int n = 0; n < 40; n++) begin
            k = mk($urandom_range(0,7), $urandom_range(0,7), $urandom_range(0,7), $urandom_range(0,7));
            do_cmd($sformatf("rnd%0d op%0d", n, k[11:9]), k, 8'($urandom), 1'b0, 8'h00);
            if (n % 8 == 7) begin
                int a;
                a = $urandom_range(0,7);
                dbg_read(3'(a), val);
                chk($sformatf("rnd dbg r%0d", a), int'(val), int'(rf_m[a]));
            end
        end
        check_all_regs("final");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
